// File: rtl/crc_arb_pkg.sv
// Shared state encoding and default widths for the CRC frame arbiter.
// Optional CRC wait timeout is enabled with the CRC_TIMEOUT_EN macro.
package crc_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STREAM   = 2'd1,
    S_WAIT_CRC = 2'd2,
    S_RESULT   = 2'd3
  } state_e;

  localparam int NUM_REQ_D     = 4;
  localparam int DATA_W_D      = 8;
  localparam int CRC_W_D       = 8;
  localparam int TIMEOUT_CYC_D = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick, searching upward from last_i + 1.
// Produces a one-hot grant, its index and an any-request flag.
module rr_arbiter
  import crc_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_D,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(last_i) + i) % NUM_REQ;
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/crc_frame_arbiter.sv
// Shares one byte-wide CRC engine among NUM_REQ frame requesters.
// Define CRC_TIMEOUT_EN to bound the CRC wait to TIMEOUT_CYC cycles.
module crc_frame_arbiter
  import crc_arb_pkg::*;
#(
  parameter  int NUM_REQ     = NUM_REQ_D,
  parameter  int DATA_W      = DATA_W_D,
  parameter  int CRC_W       = CRC_W_D,
  parameter  int TIMEOUT_CYC = TIMEOUT_CYC_D,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      eng_valid_o,
  output logic [DATA_W-1:0]         eng_data_o,
  output logic                      eng_last_o,
  input  logic                      eng_ready_i,
  input  logic [CRC_W-1:0]          eng_crc_i,
  input  logic                      eng_crc_valid_i,
  output logic [NUM_REQ-1:0]        res_valid_o,
  output logic [CRC_W-1:0]          res_crc_o,
  output logic                      res_err_o,
  output logic [IDX_W-1:0]          grant_id_o,
  output logic                      busy_o
);

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  state_e               state_q;
  logic [IDX_W-1:0]     grant_q;
  logic [NUM_REQ-1:0]   gnt_oh_q;
  logic [IDX_W-1:0]     last_q;
  logic [NUM_REQ-1:0]   res_valid_q;
  logic [CRC_W-1:0]     res_crc_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;
  logic                 beat_last;

`ifdef CRC_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0]     cnt_q;
  logic                 res_err_q;
  assign res_err_o = res_err_q;
`else
  assign res_err_o = 1'b0;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  // Byte path is a pure mux of the granted lane while streaming.
  always_comb begin
    eng_valid_o = 1'b0;
    eng_data_o  = '0;
    eng_last_o  = 1'b0;
    req_ready_o = '0;
    if (state_q == S_STREAM) begin
      eng_valid_o = req_valid_i[grant_q];
      eng_data_o  = req_data_i[int'(grant_q)*DATA_W +: DATA_W];
      eng_last_o  = req_last_i[grant_q];
      req_ready_o = gnt_oh_q & {NUM_REQ{eng_ready_i}};
    end
  end

  assign beat_last   = eng_valid_o & eng_ready_i & eng_last_o;
  assign res_valid_o = res_valid_q;
  assign res_crc_o   = res_crc_q;
  assign grant_id_o  = grant_q;
  assign busy_o      = (state_q != S_IDLE);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      gnt_oh_q    <= '0;
      last_q      <= LAST_RST;
      res_valid_q <= '0;
      res_crc_q   <= '0;
`ifdef CRC_TIMEOUT_EN
      cnt_q       <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arb_any) begin
            grant_q  <= arb_idx;
            gnt_oh_q <= arb_gnt;
            state_q  <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (beat_last) begin
            state_q <= S_WAIT_CRC;
`ifdef CRC_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        S_WAIT_CRC: begin
          // A CRC arriving on the expiry cycle still wins.
          if (eng_crc_valid_i) begin
            res_crc_q   <= eng_crc_i;
            res_valid_q <= gnt_oh_q;
            state_q     <= S_RESULT;
`ifdef CRC_TIMEOUT_EN
            res_err_q   <= 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            res_crc_q   <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= gnt_oh_q;
            state_q     <= S_RESULT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        S_RESULT: begin
          res_valid_q <= '0;
          last_q      <= grant_q;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_arbiter.sv
// Directed scoreboard bench for crc_frame_arbiter with a behavioural
// CRC engine (xor of frame bytes ^ 8'hCD) and per-lane requesters.
module tb_crc_frame_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           eng_valid;
  logic [7:0]     eng_data;
  logic           eng_last;
  logic           eng_ready;
  logic [7:0]     eng_crc = 8'h00;
  logic           eng_crc_valid = 1'b0;
  logic [N-1:0]   res_valid;
  logic [7:0]     res_crc;
  logic           res_err;
  logic [1:0]     grant_id;
  logic           busy;

  always #5 clk = ~clk;

  crc_frame_arbiter #(
    .NUM_REQ(N), .DATA_W(8), .CRC_W(8), .TIMEOUT_CYC(TO)
  ) dut (
    .clock_i         (clk),
    .reset_i         (rst),
    .req_valid_i     (req_valid),
    .req_data_i      (req_data),
    .req_last_i      (req_last),
    .req_ready_o     (req_ready),
    .eng_valid_o     (eng_valid),
    .eng_data_o      (eng_data),
    .eng_last_o      (eng_last),
    .eng_ready_i     (eng_ready),
    .eng_crc_i       (eng_crc),
    .eng_crc_valid_i (eng_crc_valid),
    .res_valid_o     (res_valid),
    .res_crc_o       (res_crc),
    .res_err_o       (res_err),
    .grant_id_o      (grant_id),
    .busy_o          (busy)
  );

  typedef struct packed {
    logic [3:0]  v;
    logic [7:0]  crc;
    logic        err;
    logic [31:0] cy;
  } got_t;

  typedef struct packed {
    logic [3:0] v;
    logic [7:0] crc;
    logic       err;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  got_t got_arr [64];
  int   got_n = 0;
  int   rd = 0;
  int   ready_viol = 0;
  logic [8:0] beat_arr [256];
  int   beat_cy [256];
  int   beat_n = 0;
  exp_t exp_q [$];

  logic [7:0] frm [N][8];
  int   frm_len [N];
  int   go_cnt [N];
  int   gap_pos [N];
  int   gap_len [N];
  bit   resp_en = 1'b1;
  bit   bp_mode = 1'b0;
  int   spur_at = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine model and output monitor.
  logic [7:0] acc = 8'h00;
  logic [7:0] acc_done = 8'h00;
  int cd = 0;
  always @(negedge clk) begin
    eng_crc_valid = 1'b0;
    if (rst) begin
      cd  = 0;
      acc = 8'h00;
    end else begin
      if (res_valid != 0 && got_n < 64) begin
        got_arr[got_n] = {res_valid, res_crc, res_err, cyc};
        got_n++;
      end
      if ((req_ready & ~(4'b0001 << grant_id)) != 0) ready_viol++;
      if (cyc == spur_at) begin
        eng_crc_valid = 1'b1;
        eng_crc = 8'h3C;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          eng_crc_valid = 1'b1;
          eng_crc = acc_done;
        end
      end
      if (eng_valid && eng_ready) begin
        if (beat_n < 256) begin
          beat_arr[beat_n] = {eng_last, eng_data};
          beat_cy[beat_n] = cyc;
          beat_n++;
        end
        acc ^= eng_data;
        if (eng_last) begin
          acc_done = acc ^ 8'hCD;
          acc = 8'h00;
          if (resp_en) cd = 2;
        end
      end
    end
  end

  initial begin
    eng_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      eng_ready = bp_mode ? ~eng_ready : 1'b1;
    end
  end

  // Requesters: hold each byte until accepted, optional mid-frame gap.
  initial begin
    int pos [N];
    int done [N];
    int gapc [N];
    bit gapped [N];
    logic [N-1:0] xf;
    bit act;
    for (int l = 0; l < N; l++) begin
      pos[l] = 0; done[l] = 0; gapc[l] = 0; gapped[l] = 1'b0;
    end
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      xf = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int l = 0; l < N; l++) begin
        if (rst) begin
          done[l] = go_cnt[l]; pos[l] = 0; gapc[l] = 0; gapped[l] = 1'b0;
        end else if (xf[l]) begin
          pos[l]++;
          if (pos[l] >= frm_len[l]) begin
            done[l]++; pos[l] = 0; gapped[l] = 1'b0;
          end
        end
        if (go_cnt[l] > done[l] && gap_len[l] > 0 &&
            pos[l] == gap_pos[l] && !gapped[l]) begin
          gapc[l] = gap_len[l];
          gapped[l] = 1'b1;
        end
        act = (go_cnt[l] > done[l]) && (gapc[l] == 0);
        if (gapc[l] > 0) gapc[l]--;
        req_valid[l] = act;
        req_data[l*8 +: 8] = frm[l][pos[l]];
        req_last[l] = act && (pos[l] == frm_len[l] - 1);
      end
    end
  end

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] xcrc(int l);
    logic [7:0] a = 8'hCD;
    for (int k = 0; k < frm_len[l]; k++) a ^= frm[l][k];
    return a;
  endfunction

  task automatic push(int l);
    exp_q.push_back({4'b0001 << l, xcrc(l), 1'b0});
  endtask

  task automatic expect_res(string tag, output int rcy);
    exp_t e;
    got_t g;
    bit   seen = 1'b0;
    rcy = -1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = (got_n > rd);
    end
    if (!seen || exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=no_result expected=result", tag);
      return;
    end
    e = exp_q.pop_front();
    g = got_arr[rd];
    rd++;
    chk({tag, ".res_valid"}, 32'(g.v), 32'(e.v));
    chk({tag, ".res_crc"}, 32'(g.crc), 32'(e.crc));
    chk({tag, ".res_err"}, 32'(g.err), 32'(e.err));
    rcy = int'(g.cy);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
  endtask

  initial begin
    int rcy;
    int b0;
    for (int l = 0; l < N; l++) begin
      frm_len[l] = 1; go_cnt[l] = 0; gap_pos[l] = 0; gap_len[l] = 0;
      for (int k = 0; k < 8; k++) frm[l][k] = 8'h00;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 0);
    chk("rst.eng_valid", 32'(eng_valid), 0);
    chk("rst.eng_data", 32'(eng_data), 0);
    chk("rst.eng_last", 32'(eng_last), 0);
    chk("rst.res_valid", 32'(res_valid), 0);
    chk("rst.res_crc", 32'(res_crc), 0);
    chk("rst.res_err", 32'(res_err), 0);
    chk("rst.grant_id", 32'(grant_id), 0);
    chk("rst.busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    tick();

    // Single-byte frame from requester 0.
    frm[0][0] = 8'h68;
    frm_len[0] = 1;
    b0 = beat_n;
    exp_q.push_back({4'b0001, 8'hA5, 1'b0});
    go_cnt[0]++;
    expect_res("single", rcy);
    chk("single.beats", 32'(beat_n - b0), 1);
    chk("single.byte", 32'(beat_arr[b0]), 32'h168);
    chk("single.latency", 32'(rcy - beat_cy[b0]), 3);
    @(negedge clk);
    #1;
    chk("single.busy_after", 32'(busy), 0);
    chk("single.res_valid_after", 32'(res_valid), 0);
    chk("single.res_crc_hold", 32'(res_crc), 32'hA5);

    // All four requesters contend; round-robin from a fresh reset.
    pulse_reset();
    for (int l = 0; l < N; l++) begin
      frm_len[l] = 3;
      for (int k = 0; k < 3; k++) frm[l][k] = 8'(8'h10 * (l + 1) + k);
    end
    push(0); push(1); push(2); push(3); push(0);
    go_cnt[0] += 2;
    go_cnt[1]++; go_cnt[2]++; go_cnt[3]++;
    for (int i = 0; i < 5; i++) expect_res($sformatf("rr%0d", i), rcy);

    // Backpressure plus a 5-cycle valid gap mid-frame.
    frm[1][0] = 8'h11; frm[1][1] = 8'h22;
    frm[1][2] = 8'h33; frm[1][3] = 8'h44;
    frm_len[1] = 4;
    gap_pos[1] = 2; gap_len[1] = 5;
    bp_mode = 1'b1;
    b0 = beat_n;
    push(1);
    go_cnt[1]++;
    expect_res("bp", rcy);
    bp_mode = 1'b0;
    gap_len[1] = 0;
    chk("bp.beats", 32'(beat_n - b0), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("bp.byte%0d", k), 32'(beat_arr[b0 + k]),
          32'({k == 3, frm[1][k]}));

    // Spurious CRC strobe while streaming requester 2.
    frm[2][0] = 8'hA1; frm[2][1] = 8'hB2;
    frm[2][2] = 8'hC3; frm[2][3] = 8'hD4;
    frm_len[2] = 4;
    gap_pos[2] = 1; gap_len[2] = 5;
    bp_mode = 1'b1;
    push(2);
    go_cnt[2]++;
    repeat (3) tick();
    spur_at = cyc + 1;
    chk("spur.grant", 32'(grant_id), 2);
    chk("spur.busy", 32'(busy), 1);
    expect_res("spur", rcy);
    bp_mode = 1'b0;

    // Reset in the middle of requester 2's frame.
    go_cnt[2]++;
    repeat (4) tick();
    chk("midrst.grant_pre", 32'(grant_id), 2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst.req_ready", 32'(req_ready), 0);
    chk("midrst.eng_valid", 32'(eng_valid), 0);
    chk("midrst.eng_data", 32'(eng_data), 0);
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.grant_id", 32'(grant_id), 0);
    chk("midrst.res_valid", 32'(res_valid), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    gap_len[2] = 0;
    tick();
    push(1); push(3);
    go_cnt[1]++; go_cnt[3]++;
    expect_res("postrst1", rcy);
    expect_res("postrst3", rcy);

    // Engine never answers.
    resp_en = 1'b0;
    frm[0][0] = 8'h5A;
    frm_len[0] = 1;
    b0 = beat_n;
`ifdef CRC_TIMEOUT_EN
    exp_q.push_back({4'b0001, 8'h00, 1'b1});
    go_cnt[0]++;
    expect_res("timeout", rcy);
    chk("timeout.latency", 32'(rcy - beat_cy[b0]), TO + 1);
`else
    go_cnt[0]++;
    repeat (40) tick();
    chk("noto.busy", 32'(busy), 1);
    chk("noto.no_result", 32'(got_n - rd), 0);
`endif
    resp_en = 1'b1;
    pulse_reset();
    repeat (3) tick();

    chk("ready_onehot", 32'(ready_viol), 0);
    chk("no_extra_results", 32'(got_n - rd), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc_frame_arbiter.md
# crc_frame_arbiter

Round-robin controller that shares one byte-wide CRC engine (8-bit data in, last flag, CRC result out) among NUM_REQ frame requesters. Grants the engine to one requester per frame, streams that requester's bytes through with valid/ready flow control, waits for the engine's CRC, and returns the result to the granted requester. Sits between the requesting stream sources and the single CRC engine instance in the block design.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width fed to the engine
- CRC_W, 8, CRC result width
- TIMEOUT_CYC, 64, CRC wait limit in cycles; used only with CRC_TIMEOUT_EN

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*DATA_W  packed bytes, requester i at [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  final byte of frame
- req_ready  out  NUM_REQ  byte accepted; only the granted bit can be high
- eng_valid  out  1  byte to engine valid
- eng_data  out  DATA_W  byte to engine
- eng_last  out  1  final byte to engine
- eng_ready  in  1  engine accepts byte
- eng_crc  in  CRC_W  engine result
- eng_crc_valid  in  1  engine result strobe
- res_valid  out  NUM_REQ  one-hot, one-cycle result strobe to the granted requester
- res_crc  out  CRC_W  result, held until the next result
- res_err  out  1  result is a timeout, valid with res_valid
- grant_id  out  $clog2(NUM_REQ)  current/last granted requester
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, STREAM, WAIT_CRC, RESULT.
- IDLE: if any req_valid bit is high, pick the first set bit searching upward from (last_grant+1) mod NUM_REQ; register grant_id; go STREAM. Otherwise stay.
- STREAM: combinational pass-through of the granted lane: eng_valid=req_valid[g], eng_data=req_data[g], eng_last=req_last[g], req_ready[g]=eng_ready. All other req_ready bits are 0. A beat transfers on a cycle with eng_valid&eng_ready. A transferred beat with eng_last high goes to WAIT_CRC.
- WAIT_CRC: eng_valid=0. On eng_crc_valid, capture eng_crc into res_crc, set res_err=0, go RESULT.
- RESULT: res_valid[g]=1 for exactly one cycle; last_grant<=g; go IDLE.
- eng_crc_valid outside WAIT_CRC is ignored.
- req_valid dropping mid-frame stalls the frame. The grant is held and the arbiter does not re-arbitrate.
- Single-byte frame (valid&last on first beat) is legal: STREAM lasts one transfer cycle.
- Requests are sampled only in IDLE. Non-granted requesters see req_ready=0 and must hold their data.

## Timing
- Reset values: req_ready=0, eng_valid=0, eng_data=0, eng_last=0, res_valid=0, res_crc=0, res_err=0, grant_id=0, busy=0. last_grant=NUM_REQ-1, so requester 0 has first priority. State=IDLE.
- Arbitration latency: req_valid high in IDLE at cycle 0 -> STREAM from cycle 1. The first byte can transfer in cycle 1.
- Byte path: zero latency (combinational) from req_* to eng_* and from eng_ready to req_ready.
- Result latency: eng_crc_valid sampled at edge n -> res_valid high during cycle n+1 -> IDLE in cycle n+2.
- Back-to-back: the earliest next grant is STREAM in cycle n+3.
- Reset asserted mid-frame: all outputs take reset values asynchronously. The partial frame is discarded with no res_valid. The engine must be reset by the same reset.

## Configuration
- CRC_TIMEOUT_EN defined:
  - A counter runs in WAIT_CRC.
  - If eng_crc_valid is absent for TIMEOUT_CYC cycles, go RESULT with res_err=1 and res_crc=0.
  - eng_crc_valid on the same cycle as expiry wins, and the result is normal.
- CRC_TIMEOUT_EN not defined:
  - The counter is not built and res_err is tied 0.
  - WAIT_CRC waits indefinitely.

## Structure
- Package crc_arb_pkg: state encoding (IDLE=0, STREAM=1, WAIT_CRC=2, RESULT=3) and the default width constants.
- Sub-module rr_arbiter: combinational round-robin pick from a request vector and last_grant. Outputs a one-hot grant and an index.
- The FSM, lane mux and timeout counter live in crc_frame_arbiter.

## Test plan
- Single frame: requester 0 sends 8'h68 with last; engine model returns 8'hA5 two cycles later -> res_valid=4'b0001, res_crc=8'hA5, res_err=0, busy=0 afterwards.
- All four requesters hold 3-byte frames -> grant order 0,1,2,3,0. Each res_valid is one-hot on the matching bit, and no other lane's req_ready is ever high.
- Backpressure: eng_ready toggles every other cycle and req_valid drops for 5 cycles mid-frame -> the engine sees exactly the 4 bytes in order, with eng_last on the 4th only.
- Reset asserted during STREAM of requester 2 -> outputs at reset values that cycle, no res_valid. The next frame from requester 1 is granted first after reset.
- CRC_TIMEOUT_EN with TIMEOUT_CYC=16 and the engine never answering -> res_valid on the granted bit 16 cycles after WAIT_CRC entry, res_err=1, res_crc=0. Without the macro, busy stays 1.
- Spurious eng_crc_valid during STREAM -> ignored; the true CRC after last is the one reported.
